can_tx_multi_arbiter: RTL



---
 rtl/can_tx_multi_arbiter_pkg.sv | 27 ++
 rtl/can_tx_multi_arbiter_if.sv | 28 ++
 rtl/can_tx_multi_arbiter_arb_select.sv | 50 +++++
 rtl/can_tx_multi_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/can_tx_multi_arbiter_pkg.sv
// Shared types and helpers for the multi-source CAN TX arbiter.
// Holds the FSM state enum, the arbitration mode codes and the frame-ID extractor.
package can_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        SEND,
        WAIT_DONE
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_ID    = 1'b1;

    // Upper bounds for get_id; callers zero-extend their word and truncate the result.
    localparam int MAX_WORD_W = 1024;
    localparam int MAX_ID_W   = 32;

    function automatic logic [MAX_ID_W-1:0] get_id(input logic [MAX_WORD_W-1:0] word,
                                                   input int unsigned         lsb);
        logic [MAX_WORD_W-1:0] shifted;
        shifted = word >> lsb;
        return shifted[MAX_ID_W-1:0];
    endfunction

endpackage

// File: rtl/can_tx_multi_arbiter_if.sv
// Source/transmitter signal bundle of the CAN TX arbiter.
// master = arbiter side, slave = sources plus transmit engine.
interface can_tx_multi_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 128
);
    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        i_req;
    logic [NUM_SRC*DATA_W-1:0] i_data;
    logic                      i_busy_can;
    logic [NUM_SRC-1:0]        o_rd_en;
    logic [DATA_W-1:0]         o_send_data;
    logic                      o_send_en;
    logic [IDX_W-1:0]          o_grant_idx;
    logic                      o_tx_done;

    modport master (
        input  i_req, i_data, i_busy_can,
        output o_rd_en, o_send_data, o_send_en, o_grant_idx, o_tx_done
    );

    modport slave (
        output i_req, i_data, i_busy_can,
        input  o_rd_en, o_send_data, o_send_en, o_grant_idx, o_tx_done
    );

endinterface

// File: rtl/can_tx_multi_arbiter_arb_select.sv
// Combinational winner select: aged requesters first (lowest index), else
// lowest requesting index (MODE_FIXED) or smallest ID with index tie-break (MODE_ID).
module can_tx_arb_select
    import can_tx_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 11,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                    mode,
    input  logic [NUM_SRC-1:0]      req,
    input  logic [NUM_SRC*ID_W-1:0] ids,
    input  logic [NUM_SRC-1:0]      aged,
    output logic [IDX_W-1:0]        win_idx,
    output logic                    win_valid
);

    logic [NUM_SRC-1:0] aged_req;
    logic [ID_W-1:0]    best_id;
    logic               found;

    assign aged_req = aged & req;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        win_idx   = '0;
        win_valid = |req;
        best_id   = '0;
        found     = 1'b0;
        if (|aged_req) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                if (aged_req[k]) win_idx = IDX_W'(k);
            end
        end else if (mode == MODE_FIXED) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                if (req[k]) win_idx = IDX_W'(k);
            end
        end else begin
            // Strict '<' keeps the earlier (lower) index on equal IDs.
            for (int k = 0; k < NUM_SRC; k++) begin
                if (req[k] && (!found || (ids[k*ID_W +: ID_W] < best_id))) begin
                    found   = 1'b1;
                    best_id = ids[k*ID_W +: ID_W];
                    win_idx = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/can_tx_multi_arbiter.sv
// TX arbiter: picks one of NUM_SRC sources per frame, pops it, holds the frame for
// the CAN transmitter and tracks completion via busy. Aging enabled by CAN_TX_AGING_EN.
module can_tx_multi_arbiter
    import can_tx_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 11,
    parameter int ID_LSB    = 117,
    parameter int AGE_LIMIT = 8
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    input  logic                  i_cen,
    input  logic                  i_mode,
    can_tx_multi_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_SRC);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          win_idx_q;
    logic [DATA_W-1:0]         latch_q;
    logic                      tx_done_q;
    logic [NUM_SRC*ID_W-1:0]   ids;
    logic [NUM_SRC-1:0]        aged;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_valid;
    logic                      arb_fire;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_id
        assign ids[k*ID_W +: ID_W] =
            ID_W'(get_id(MAX_WORD_W'(bus.i_data[k*DATA_W +: DATA_W]), ID_LSB));
    end

    can_tx_arb_select #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W),
        .IDX_W   (IDX_W)
    ) u_select (
        .mode      (i_mode),
        .req       (bus.i_req),
        .ids       (ids),
        .aged      (aged),
        .win_idx   (sel_idx),
        .win_valid (sel_valid)
    );

    assign arb_fire = (state_q == ARB) && i_cen && !bus.i_busy_can && sel_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (i_cen) state_d = ARB;
            ARB: begin
                if (!i_cen)       state_d = IDLE;
                else if (arb_fire) state_d = LOAD;
            end
            LOAD:      state_d = SEND;
            SEND:      if (bus.i_busy_can) state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.i_busy_can) state_d = i_cen ? ARB : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            win_idx_q <= '0;
            latch_q   <= '0;
            tx_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            state_q   <= state_d;
            tx_done_q <= (state_q == WAIT_DONE) && !bus.i_busy_can;
            if (arb_fire) win_idx_q <= sel_idx;
            if (state_q == LOAD) latch_q <= bus.i_data[win_idx_q*DATA_W +: DATA_W];
        end
    end

`ifdef CAN_TX_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_q [NUM_SRC];

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_SRC; k++) age_q[k] <= '0;
        end else if (arb_fire) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (sel_idx == IDX_W'(k) || !bus.i_req[k])
                    age_q[k] <= '0;
                else if (age_q[k] != AGE_W'(AGE_LIMIT))
                    age_q[k] <= age_q[k] + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_aged
        assign aged[k] = (age_q[k] == AGE_W'(AGE_LIMIT));
    end
`else
    assign aged = '0;
`endif

    assign bus.o_rd_en     = (state_q == LOAD) ? (NUM_SRC'(1) << win_idx_q) : '0;
    assign bus.o_send_en   = (state_q == SEND);
    assign bus.o_send_data = latch_q;
    assign bus.o_grant_idx = win_idx_q;
    assign bus.o_tx_done   = tx_done_q;

endmodule
